peridot_cam_avm_stride: RTL

Parametrised Avalon-MM burst write master for the PERIDOT camera capture path. It stores a 2D frame as line_num lines of line_chunks bursts each, with a programmable byte stride between line starts. Data width and burst length are generic. It adds continuous (ring) capture and a clean abort that always completes the burst in flight. It sits between the pixel-packing FIFO and the Avalon interconnect.

---
 rtl/peridot_cam_avm_stride_if.sv | 26 ++
 rtl/peridot_cam_avm_stride.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/peridot_cam_avm_stride_if.sv
// Avalon-MM burst write bus between the camera stride master and the interconnect.
interface peridot_cam_avm_stride_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
);
    localparam int BCW = $clog2(BURST_LEN) + 1;

    logic [31:0]             avm_m1_address;
    logic                    avm_m1_write;
    logic [DATA_WIDTH-1:0]   avm_m1_writedata;
    logic [DATA_WIDTH/8-1:0] avm_m1_byteenable;
    logic [BCW-1:0]          avm_m1_burstcount;
    logic                    avm_m1_waitrequest;

    modport master (
        output avm_m1_address, avm_m1_write, avm_m1_writedata,
               avm_m1_byteenable, avm_m1_burstcount,
        input  avm_m1_waitrequest
    );

    modport slave (
        input  avm_m1_address, avm_m1_write, avm_m1_writedata,
               avm_m1_byteenable, avm_m1_burstcount,
        output avm_m1_waitrequest
    );
endinterface

// File: rtl/peridot_cam_avm_stride.sv
// Avalon-MM burst write master: 2D frame of line_num lines x line_chunks bursts
// with programmable line stride, optional ring capture and burst-boundary abort.
//
// state | meaning
// IDLE  | waiting for start, done high
// SETUP | waiting for FIFO to hold a full burst (or leaving on abort)
// BURST | streaming BURST_LEN words at a fixed address
// NEXT  | advance chunk / line / frame address
// DONE  | one cycle before IDLE, clears abort latch
module peridot_cam_avm_stride #(
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   avm_m1_clk,
    input  logic                   csi_global_reset,
    peridot_cam_avm_stride_if.master avm,
    input  logic [31:0]            address_top,
    input  logic [COUNT_WIDTH-1:0] line_chunks,
    input  logic [COUNT_WIDTH-1:0] line_num,
    input  logic [31:0]            line_stride,
    input  logic                   continuous,
    input  logic                   start,
    input  logic                   abort,
    output logic                   done,
    output logic                   frame_end,
    input  logic                   writedata_ready,
    input  logic [DATA_WIDTH-1:0]  writedata,
    output logic                   writedata_rdack
);
    localparam int BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int BCW   = $clog2(BURST_LEN) + 1;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << ALIGN) - 32'd1);
    localparam logic [31:0] BYTES_W   = 32'(BYTES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_BURST, S_NEXT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            top_q, top_d, stride_q, stride_d;
    logic [31:0]            line_base_q, line_base_d, cur_addr_q, cur_addr_d;
    logic [COUNT_WIDTH-1:0] chunks_q, chunks_d, lines_q, lines_d;
    logic [COUNT_WIDTH-1:0] chunk_cnt_q, chunk_cnt_d, line_cnt_q, line_cnt_d;
    logic [BCW-1:0]         word_cnt_q, word_cnt_d;
    logic                   cont_q, cont_d, abort_q, abort_d;
    logic                   write_q, write_d, done_q, done_d, frame_end_q, frame_end_d;

    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        stride_d    = stride_q;
        line_base_d = line_base_q;
        cur_addr_d  = cur_addr_q;
        chunks_d    = chunks_q;
        lines_d     = lines_q;
        chunk_cnt_d = chunk_cnt_q;
        line_cnt_d  = line_cnt_q;
        word_cnt_d  = word_cnt_q;
        cont_d      = cont_q;
        abort_d     = abort_q;
        write_d     = write_q;
        done_d      = done_q;
        frame_end_d = 1'b0;

        if (abort && (state_q == S_SETUP || state_q == S_BURST || state_q == S_NEXT))
            abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    top_d       = address_top & ADDR_MASK;
                    stride_d    = line_stride & ADDR_MASK;
                    line_base_d = address_top & ADDR_MASK;
                    cur_addr_d  = address_top & ADDR_MASK;
                    chunks_d    = line_chunks;
                    lines_d     = line_num;
                    chunk_cnt_d = line_chunks;
                    line_cnt_d  = line_num;
                    cont_d      = continuous;
                    done_d      = 1'b0;
                    state_d     = (line_chunks == '0 || line_num == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort_q) begin
                    state_d = S_DONE;
                end else if (writedata_ready) begin
                    write_d    = 1'b1;
                    word_cnt_d = BCW'(BURST_LEN - 1);
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (!avm.avm_m1_waitrequest) begin
                    if (word_cnt_q == '0) begin
                        write_d     = 1'b0;
                        chunk_cnt_d = chunk_cnt_q - CNT_ONE;
                        // registered so the pulse lands in the NEXT cycle
                        frame_end_d = (chunk_cnt_q == CNT_ONE) && (line_cnt_q <= CNT_ONE);
                        state_d     = S_NEXT;
                    end else begin
                        word_cnt_d = word_cnt_q - BCW'(1);
                    end
                end
            end
            S_NEXT: begin
                state_d = S_SETUP;
                if (chunk_cnt_q != '0) begin
                    cur_addr_d = cur_addr_q + BYTES_W;
                end else if (line_cnt_q > CNT_ONE) begin
                    line_cnt_d  = line_cnt_q - CNT_ONE;
                    line_base_d = line_base_q + stride_q;
                    cur_addr_d  = line_base_q + stride_q;
                    chunk_cnt_d = chunks_q;
                end else if (cont_q) begin
                    line_base_d = top_q;
                    cur_addr_d  = top_q;
                    line_cnt_d  = lines_q;
                    chunk_cnt_d = chunks_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge avm_m1_clk) begin
        if (csi_global_reset) begin
            state_q     <= S_IDLE;
            top_q       <= '0;
            stride_q    <= '0;
            line_base_q <= '0;
            cur_addr_q  <= '0;
            chunks_q    <= '0;
            lines_q     <= '0;
            chunk_cnt_q <= '0;
            line_cnt_q  <= '0;
            word_cnt_q  <= '0;
            cont_q      <= 1'b0;
            abort_q     <= 1'b0;
            write_q     <= 1'b0;
            done_q      <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            stride_q    <= stride_d;
            line_base_q <= line_base_d;
            cur_addr_q  <= cur_addr_d;
            chunks_q    <= chunks_d;
            lines_q     <= lines_d;
            chunk_cnt_q <= chunk_cnt_d;
            line_cnt_q  <= line_cnt_d;
            word_cnt_q  <= word_cnt_d;
            cont_q      <= cont_d;
            abort_q     <= abort_d;
            write_q     <= write_d;
            done_q      <= done_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign avm.avm_m1_address    = cur_addr_q;
    assign avm.avm_m1_write      = write_q;
    assign avm.avm_m1_writedata  = writedata;
    assign avm.avm_m1_byteenable = '1;
    assign avm.avm_m1_burstcount = BCW'(BURST_LEN);
    assign writedata_rdack       = write_q & ~avm.avm_m1_waitrequest;
    assign done                  = done_q;
    assign frame_end             = frame_end_q;
endmodule
